// File: rtl/smi_pkg.sv
// Shared constants for the SMI stream bridge: register map, status layout and TX framing states.
package smi_pkg;

  localparam logic [4:0] IOC_VERSION = 5'd0;
  localparam logic [4:0] IOC_STATUS  = 5'd1;
  localparam logic [4:0] IOC_CHANNEL = 5'd2;
  localparam logic [4:0] IOC_CTRL    = 5'd3;

  localparam logic [7:0] MODULE_VERSION    = 8'h02;
  localparam logic [7:0] TEST_SEED_DEFAULT = 8'h56;

  localparam int ST_EMPTY    = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TEST     = 2;
  localparam int ST_RX_UDF   = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_SYNC_ERR = 5;

  localparam int CTRL_TEST = 0;
  localparam int CTRL_CLR  = 1;

  typedef enum logic {
    TX_HDR = 1'b0,
    TX_PAY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/smi_strobe_sync.sv
// Two-flop synchroniser for an SMI strobe pad with a one-cycle falling-edge pulse.
module smi_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic fall
);

  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], strobe};
  end

  // Reset to low so a pad idling high after reset is seen as a rising edge, never a fall.
  assign fall = sync[2] & ~sync[1];

endmodule

// File: rtl/smi_stream_ctrl.sv
// SMI byte-stream bridge: serialises RX FIFO words onto SMI and deframes SMI bytes into TX words.
module smi_stream_ctrl
  import smi_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         SMI_W     = 8,
  parameter int         N_CH      = 2,
  parameter logic [7:0] TEST_SEED = TEST_SEED_DEFAULT,
  localparam int        CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_ioc,
  input  logic [7:0]             i_data_in,
  output logic [7:0]             o_data_out,
  input  logic                   i_cs,
  input  logic                   i_fetch_cmd,
  input  logic                   i_load_cmd,
  output logic [N_CH-1:0]        o_rx_fifo_pull,
  input  logic [N_CH*DATA_W-1:0] i_rx_fifo_pulled_data,
  input  logic [N_CH-1:0]        i_rx_fifo_empty,
  output logic                   o_tx_fifo_push,
  output logic [DATA_W-1:0]      o_tx_fifo_pushed_data,
  input  logic                   i_tx_fifo_full,
  input  logic                   i_smi_soe_se,
  input  logic                   i_smi_swe_srw,
  output logic [SMI_W-1:0]       o_smi_data_out,
  input  logic [SMI_W-1:0]       i_smi_data_in,
  output logic                   o_smi_read_req,
  output logic                   o_smi_write_req,
  output logic [CH_W-1:0]        o_channel,
  output logic                   o_cond_tx,
  output logic                   o_address_error
);

  localparam int              NB    = DATA_W / SMI_W;
  localparam int              CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  logic soe_fire, swe_fire;
  logic test_mode, clr_sticky;
  logic rx_udf, tx_ovf, sync_err;
  logic rx_udf_set, tx_ovf_set, sync_set;
  logic [CH_W-1:0]   ch_pend;
  logic [CNT_W-1:0]  cnt, k;
  logic [DATA_W-1:0] hr, sr, tx_word;
  logic [7:0]        lfsr, status;
  logic active_empty, reg_access, ioc_known, do_fetch, do_load, ch_wr_bad;
  logic cond, tx_done;
  tx_state_t tx_state, tx_next;
  logic unused_ok;

  smi_strobe_sync u_soe_sync (.clk(i_sys_clk), .rst(i_rst), .strobe(i_smi_soe_se),  .fall(soe_fire));
  smi_strobe_sync u_swe_sync (.clk(i_sys_clk), .rst(i_rst), .strobe(i_smi_swe_srw), .fall(swe_fire));

  assign unused_ok    = &{1'b0, i_data_in};
  assign active_empty = i_rx_fifo_empty[o_channel];
  assign reg_access   = i_cs & (i_fetch_cmd | i_load_cmd);
  assign ioc_known    = (i_ioc <= IOC_CTRL);
  assign do_fetch     = i_cs & i_fetch_cmd;
  assign do_load      = i_cs & i_load_cmd & ~i_fetch_cmd;
  assign ch_wr_bad    = do_load & (i_ioc == IOC_CHANNEL) & (int'(i_data_in[CH_W-1:0]) >= N_CH);
  assign clr_sticky   = do_load & (i_ioc == IOC_CTRL) & i_data_in[CTRL_CLR];
  assign rx_udf_set   = soe_fire & ~test_mode & (cnt == LAST) & active_empty;
  assign tx_ovf_set   = tx_done & i_tx_fifo_full;
  assign tx_word      = (sr << SMI_W) | DATA_W'(i_smi_data_in);

  always_comb begin
    status                = '0;
    status[ST_EMPTY]      = active_empty;
    status[ST_TX_FULL]    = i_tx_fifo_full;
    status[ST_TEST]       = test_mode;
    status[ST_RX_UDF]     = rx_udf;
    status[ST_TX_OVF]     = tx_ovf;
    status[ST_SYNC_ERR]   = sync_err;
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data_out      <= '0;
      o_address_error <= 1'b0;
      ch_pend         <= '0;
      test_mode       <= 1'b0;
    end else begin
      o_address_error <= (reg_access & ~ioc_known) | ch_wr_bad;
      if (do_fetch) begin
        case (i_ioc)
          IOC_VERSION: o_data_out <= MODULE_VERSION;
          IOC_STATUS:  o_data_out <= status;
          IOC_CHANNEL: o_data_out <= 8'(ch_pend);
          IOC_CTRL:    o_data_out <= {7'b0, test_mode};
          default:     o_data_out <= '0;
        endcase
      end else if (do_load) begin
        if (i_ioc == IOC_CHANNEL && !ch_wr_bad) ch_pend <= i_data_in[CH_W-1:0];
        if (i_ioc == IOC_CTRL) test_mode <= i_data_in[CTRL_TEST];
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_udf   <= 1'b0;
      tx_ovf   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (rx_udf_set)      rx_udf <= 1'b1;
      else if (clr_sticky) rx_udf <= 1'b0;
      if (tx_ovf_set)      tx_ovf <= 1'b1;
      else if (clr_sticky) tx_ovf <= 1'b0;
      if (sync_set)        sync_err <= 1'b1;
      else if (clr_sticky) sync_err <= 1'b0;
    end
  end

  // RX: HR shifts left one byte per read so the MSB byte is always at the top.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt             <= '0;
      hr              <= '0;
      lfsr            <= TEST_SEED;
      o_smi_data_out  <= '0;
      o_rx_fifo_pull  <= '0;
      o_channel       <= '0;
      o_smi_read_req  <= 1'b0;
      o_smi_write_req <= 1'b0;
    end else begin
      o_rx_fifo_pull  <= '0;
      o_smi_read_req  <= ~active_empty | test_mode;
      o_smi_write_req <= ~i_tx_fifo_full;
      if (cnt == '0) o_channel <= ch_pend;
      if (soe_fire) begin
        if (test_mode) begin
          o_smi_data_out <= SMI_W'(lfsr);
          lfsr <= (lfsr == '0) ? TEST_SEED : {lfsr[2] ^ lfsr[3], lfsr[7:1]};
        end else begin
          o_smi_data_out <= hr[DATA_W-1 -: SMI_W];
          if (cnt == LAST) begin
            cnt <= '0;
            if (!active_empty) begin
              o_rx_fifo_pull[o_channel] <= 1'b1;
              hr <= i_rx_fifo_pulled_data[int'(o_channel)*DATA_W +: DATA_W];
            end else begin
              hr <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            hr  <= hr << SMI_W;
          end
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) tx_state <= TX_HDR;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    sync_set = 1'b0;
    tx_done  = 1'b0;
    case (tx_state)
      TX_HDR: if (swe_fire) begin
        if (i_smi_data_in[SMI_W-1]) tx_next  = TX_PAY;
        else                        sync_set = 1'b1;
      end
      TX_PAY: if (swe_fire && k == LAST) begin
        tx_done = 1'b1;
        tx_next = TX_HDR;
      end
      default: tx_next = TX_HDR;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      k                     <= '0;
      sr                    <= '0;
      cond                  <= 1'b0;
      o_tx_fifo_push        <= 1'b0;
      o_tx_fifo_pushed_data <= '0;
      o_cond_tx             <= 1'b0;
    end else begin
      o_tx_fifo_push <= 1'b0;
      if (swe_fire) begin
        if (tx_state == TX_HDR) begin
          if (i_smi_data_in[SMI_W-1]) begin
            cond <= i_smi_data_in[SMI_W-2];
            k    <= '0;
          end
        end else begin
          sr <= tx_word;
          k  <= k + 1'b1;
        end
      end
      if (tx_done && !i_tx_fifo_full) begin
        o_tx_fifo_push        <= 1'b1;
        o_tx_fifo_pushed_data <= tx_word;
        o_cond_tx             <= cond;
      end
    end
  end

endmodule

// File: tb/tb_smi_stream_ctrl.sv
// Scoreboard bench for smi_stream_ctrl: a byte/word-level reference model predicts, monitors compare.
module tb_smi_stream_ctrl;
  localparam int DATA_W = 32, SMI_W = 8, N_CH = 2, NB = DATA_W / SMI_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]             i_ioc;
  logic [7:0]             i_data_in, o_data_out;
  logic                   i_cs, i_fetch_cmd, i_load_cmd;
  logic [N_CH-1:0]        o_rx_fifo_pull, i_rx_fifo_empty;
  logic [N_CH*DATA_W-1:0] i_rx_fifo_pulled_data;
  logic                   o_tx_fifo_push, i_tx_fifo_full;
  logic [DATA_W-1:0]      o_tx_fifo_pushed_data;
  logic                   i_smi_soe_se, i_smi_swe_srw;
  logic [SMI_W-1:0]       o_smi_data_out, i_smi_data_in;
  logic                   o_smi_read_req, o_smi_write_req, o_cond_tx, o_address_error;
  logic [0:0]             o_channel;

  smi_stream_ctrl #(.DATA_W(DATA_W), .SMI_W(SMI_W), .N_CH(N_CH), .TEST_SEED(8'h56)) dut (
    .i_sys_clk(clk), .i_rst(rst), .i_ioc(i_ioc), .i_data_in(i_data_in), .o_data_out(o_data_out),
    .i_cs(i_cs), .i_fetch_cmd(i_fetch_cmd), .i_load_cmd(i_load_cmd),
    .o_rx_fifo_pull(o_rx_fifo_pull), .i_rx_fifo_pulled_data(i_rx_fifo_pulled_data),
    .i_rx_fifo_empty(i_rx_fifo_empty), .o_tx_fifo_push(o_tx_fifo_push),
    .o_tx_fifo_pushed_data(o_tx_fifo_pushed_data), .i_tx_fifo_full(i_tx_fifo_full),
    .i_smi_soe_se(i_smi_soe_se), .i_smi_swe_srw(i_smi_swe_srw), .o_smi_data_out(o_smi_data_out),
    .i_smi_data_in(i_smi_data_in), .o_smi_read_req(o_smi_read_req), .o_smi_write_req(o_smi_write_req),
    .o_channel(o_channel), .o_cond_tx(o_cond_tx), .o_address_error(o_address_error));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO emulation and expectation queues
  logic [31:0] fifo0[$], fifo1[$];
  logic [7:0]  exp_rx_q[$], exp_reg_q[$];
  int          exp_pull_q[$];
  logic [32:0] exp_push_q[$];
  int          aerr_exp = 0, aerr_seen = 0;
  event        rx_ev, reg_ev;

  // Reference model state
  int          pos_m = 0;
  logic [31:0] hr_m = '0, tx_word_m = '0;
  int          ch_m = 0, pend_m = 0, tx_k_m = 0;
  bit          test_m = 0, udf_m = 0, ovf_m = 0, sync_m = 0, tx_pay_m = 0, tx_cond_m = 0, full_tb = 0;
  logic [7:0]  lfsr_m = 8'h56;

  assign i_tx_fifo_full = full_tb;

  function automatic int fsize(int ch);
    return (ch == 0) ? fifo0.size() : fifo1.size();
  endfunction

  function automatic int ch_eff();
    return (pos_m == 0) ? pend_m : ch_m;
  endfunction

  function automatic logic [7:0] status_m();
    return {2'b00, sync_m, ovf_m, udf_m, test_m, full_tb, (fsize(ch_eff()) == 0)};
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (o_rx_fifo_pull != '0) begin
        check("rx_pull_onehot", $countones(o_rx_fifo_pull), 1);
        for (int c = 0; c < N_CH; c++) if (o_rx_fifo_pull[c]) begin
          e = 'x;
          if (exp_pull_q.size() > 0) e = exp_pull_q.pop_front();
          check("rx_pull_chan", c, e);
          if (c == 0 && fifo0.size() > 0) void'(fifo0.pop_front());
          if (c == 1 && fifo1.size() > 0) void'(fifo1.pop_front());
        end
      end
      if (o_tx_fifo_push) begin
        e = 'x;
        if (exp_push_q.size() > 0) e = 64'(exp_push_q.pop_front());
        check("tx_push_cond_word", {o_cond_tx, o_tx_fifo_pushed_data}, e);
      end
      if (o_address_error) aerr_seen++;
    end
    i_rx_fifo_empty[0] = (fifo0.size() == 0);
    i_rx_fifo_empty[1] = (fifo1.size() == 0);
    i_rx_fifo_pulled_data = {(fifo1.size() > 0) ? fifo1[0] : 32'h0, (fifo0.size() > 0) ? fifo0[0] : 32'h0};
  end

  always @(rx_ev) begin
    logic [63:0] e;
    e = 'x;
    if (exp_rx_q.size() > 0) e = exp_rx_q.pop_front();
    check("smi_rx_byte", o_smi_data_out, e);
  end

  always @(reg_ev) begin
    logic [63:0] e;
    e = 'x;
    if (exp_reg_q.size() > 0) e = exp_reg_q.pop_front();
    check("reg_read", o_data_out, e);
  end

  task automatic fifo_push(input int ch, input logic [31:0] w);
    if (ch == 0) fifo0.push_back(w); else fifo1.push_back(w);
    repeat (2) @(negedge clk);
  endtask

  task automatic smi_rd();
    logic [7:0] b;
    if (test_m) begin
      b = lfsr_m;
      lfsr_m = (lfsr_m == 0) ? 8'h56 : 8'((lfsr_m >> 1) | ((((lfsr_m >> 2) ^ (lfsr_m >> 3)) & 8'h1) << 7));
    end else begin
      if (pos_m == 0) ch_m = pend_m;
      b = 8'(hr_m >> (8 * (NB - 1 - pos_m)));
      if (pos_m == NB - 1) begin
        if (fsize(ch_m) > 0) begin
          exp_pull_q.push_back(ch_m);
          hr_m = (ch_m == 0) ? fifo0[0] : fifo1[0];
        end else begin
          hr_m = '0;
          udf_m = 1;
        end
        pos_m = 0;
      end else pos_m++;
    end
    exp_rx_q.push_back(b);
    i_smi_soe_se = 1'b0;
    repeat (4) @(negedge clk);
    -> rx_ev;
    i_smi_soe_se = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic smi_wr(input logic [7:0] b);
    if (!tx_pay_m) begin
      if (b[7]) begin tx_pay_m = 1; tx_cond_m = b[6]; tx_k_m = 0; tx_word_m = '0; end
      else sync_m = 1;
    end else begin
      tx_word_m = (tx_word_m << 8) | 32'(b);
      tx_k_m++;
      if (tx_k_m == NB) begin
        if (!full_tb) exp_push_q.push_back({tx_cond_m, tx_word_m});
        else ovf_m = 1;
        tx_pay_m = 0;
      end
    end
    i_smi_data_in = b;
    i_smi_swe_srw = 1'b0;
    repeat (4) @(negedge clk);
    i_smi_swe_srw = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic reg_rd(input logic [4:0] ioc, input logic [7:0] exp);
    if (ioc > 3) aerr_exp++;
    exp_reg_q.push_back(exp);
    i_ioc = ioc; i_cs = 1'b1; i_fetch_cmd = 1'b1;
    @(negedge clk);
    i_cs = 1'b0; i_fetch_cmd = 1'b0;
    -> reg_ev;
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [4:0] ioc, input logic [7:0] d);
    if (ioc > 3) aerr_exp++;
    if (ioc == 2) pend_m = int'(d[0]);
    if (ioc == 3) begin
      test_m = d[0];
      if (d[1]) begin udf_m = 0; ovf_m = 0; sync_m = 0; end
    end
    i_ioc = ioc; i_data_in = d; i_cs = 1'b1; i_load_cmd = 1'b1;
    @(negedge clk);
    i_cs = 1'b0; i_load_cmd = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs();
    repeat (2) @(negedge clk);
    check("o_channel", o_channel, ch_eff());
    check("o_smi_read_req", o_smi_read_req, (fsize(ch_eff()) > 0) || test_m);
    check("o_smi_write_req", o_smi_write_req, !full_tb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_ioc = '0; i_data_in = '0; i_cs = 0; i_fetch_cmd = 0; i_load_cmd = 0;
    i_smi_soe_se = 1'b1; i_smi_swe_srw = 1'b1; i_smi_data_in = '0;
    i_rx_fifo_empty = '1; i_rx_fifo_pulled_data = '0;
    repeat (3) @(negedge clk);
    check("rst_data_out", o_data_out, 0);
    check("rst_smi_data_out", o_smi_data_out, 0);
    check("rst_write_req", o_smi_write_req, 0);
    check("rst_read_req", o_smi_read_req, 0);
    check("rst_channel", o_channel, 0);
    check("rst_push_pull", {o_tx_fifo_push, o_rx_fifo_pull, o_address_error, o_cond_tx}, 0);
    check("rst_pushed_data", o_tx_fifo_pushed_data, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    reg_rd(0, 8'h02);
    reg_rd(1, status_m());
    check_outputs();

    // RX word stream on ch0
    fifo_push(0, 32'hDEADBEEF);
    fifo_push(0, $urandom);
    for (int i = 0; i < 8; i++) smi_rd();
    fifo_push(0, $urandom);
    fifo_push(0, $urandom);
    for (int i = 0; i < 8; i++) smi_rd();

    // RX underrun on empty ch1, then sticky clear
    reg_wr(2, 8'd1);
    check_outputs();
    for (int i = 0; i < 8; i++) smi_rd();
    reg_rd(1, status_m());
    reg_wr(3, 8'h02);
    reg_rd(1, status_m());
    reg_wr(2, 8'd0);

    // TX framing, overflow and sync recovery
    smi_wr(8'hC0); smi_wr(8'h12); smi_wr(8'h34); smi_wr(8'h56); smi_wr(8'h78);
    full_tb = 1;
    smi_wr(8'hC0); smi_wr(8'h12); smi_wr(8'h34); smi_wr(8'h56); smi_wr(8'h78);
    reg_rd(1, status_m());
    check_outputs();
    full_tb = 0;
    smi_wr(8'h05); smi_wr(8'h80); smi_wr(8'hAA); smi_wr(8'hBB); smi_wr(8'hCC); smi_wr(8'hDD);
    reg_rd(1, status_m());
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 4) != 0) b[7] = 1'b1;
      if ($urandom_range(0, 7) == 0) full_tb = !full_tb;
      smi_wr(b);
    end
    full_tb = 0;
    reg_rd(1, status_m());
    reg_wr(3, 8'h02);

    // Test mode: LFSR bytes, no pulls, read request forced
    reg_wr(3, 8'h01);
    check_outputs();
    for (int i = 0; i < 3; i++) smi_rd();
    reg_rd(3, 8'h01);
    reg_rd(1, status_m());
    reg_wr(3, 8'h00);

    // Channel change staged to the word boundary
    fifo_push(0, $urandom);
    fifo_push(1, $urandom);
    fifo_push(1, $urandom);
    for (int i = 0; i < 4; i++) smi_rd();
    smi_rd();
    reg_wr(2, 8'd1);
    check_outputs();
    reg_rd(2, 8'd1);
    for (int i = 0; i < 3; i++) smi_rd();
    check_outputs();
    for (int i = 0; i < 8; i++) smi_rd();

    // Undefined register accesses
    reg_rd(5'd9, 8'h00);
    check("addr_err_pulse_count", aerr_seen, aerr_exp);
    reg_wr(5'd12, 8'hFF);
    reg_rd(3, {7'b0, test_m});

    // Mixed random traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: smi_rd();
        1: begin
          logic [7:0] b;
          b = 8'($urandom);
          if ($urandom_range(0, 4) != 0) b[7] = 1'b1;
          smi_wr(b);
        end
        2: begin
          int c;
          c = $urandom_range(0, 1);
          if (fsize(c) < 3) fifo_push(c, $urandom);
        end
        3: reg_wr(2, 8'($urandom_range(0, 1)));
        4: reg_rd(1, status_m());
        default: begin
          full_tb = !full_tb;
          check_outputs();
        end
      endcase
    end

    repeat (6) @(negedge clk);
    check("rx_byte_queue_drained", exp_rx_q.size(), 0);
    check("pull_queue_drained", exp_pull_q.size(), 0);
    check("push_queue_drained", exp_push_q.size(), 0);
    check("addr_err_total", aerr_seen, aerr_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
